// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected output stage: default sizes,
// score/index types and the argmax controller state encoding.
package fc_pkg;

  localparam int N_CLASS = 10;
  localparam int SCORE_W = 38;
  localparam int IDX_W   = 4;

  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic [IDX_W-1:0]          class_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } fc_argmax_state_t;

endpackage

// File: rtl/fc_argmax.sv
// Latches all class scores once every neuron is done, then scans them one per
// cycle with a single signed comparator. Define FC_ARGMAX_SCORE_EN to expose max_score_o.
module fc_argmax #(
  parameter int N_CLASS = fc_pkg::N_CLASS,
  parameter int SCORE_W = fc_pkg::SCORE_W,
  parameter int IDX_W   = fc_pkg::IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [N_CLASS*SCORE_W-1:0] score_i,
  input  logic [N_CLASS-1:0]         done_i,
  output logic [IDX_W-1:0]           class_o,
  output logic                       class_valid_o,
`ifdef FC_ARGMAX_SCORE_EN
  output logic [SCORE_W-1:0]         max_score_o,
`endif
  output logic                       busy_o
);
  import fc_pkg::*;

  typedef logic signed [SCORE_W-1:0] sc_t;

  fc_argmax_state_t state, state_n;

  logic [N_CLASS-1:0][SCORE_W-1:0] bank;
  sc_t              best, cand;
  logic [IDX_W-1:0] best_idx, k;
  logic             all_done, gt, last, busy_n;

  assign all_done = &done_i;
  assign cand     = sc_t'(bank[k]);
  assign gt       = cand > best;
  assign last     = (k == IDX_W'(N_CLASS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state: enable low always wins and returns to IDLE
  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = WAIT;
        WAIT:    if (all_done) state_n = SCAN;
        SCAN:    if (last) state_n = DONE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs: busy is registered from the state being entered
  always_comb begin
    busy_n = (state_n == WAIT) || (state_n == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_o <= 1'b0;
    else     busy_o <= busy_n;
  end

  // Score bank, running best and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank          <= '0;
      best          <= '0;
      best_idx      <= '0;
      k             <= '0;
      class_o       <= '0;
      class_valid_o <= 1'b0;
`ifdef FC_ARGMAX_SCORE_EN
      max_score_o   <= '0;
`endif
    end else if (!enable) begin
      k             <= '0;
      class_valid_o <= 1'b0;
    end else begin
      unique case (state)
        WAIT: if (all_done) begin
          bank     <= score_i;
          best     <= sc_t'(score_i[SCORE_W-1:0]);
          best_idx <= '0;
          k        <= IDX_W'(1);
        end
        SCAN: begin
          // Strict compare: on a tie the earlier (lower) index survives
          if (gt) begin
            best     <= cand;
            best_idx <= k;
          end
          if (last) begin
            k             <= '0;
            class_o       <= gt ? k : best_idx;
            class_valid_o <= 1'b1;
`ifdef FC_ARGMAX_SCORE_EN
            max_score_o   <= gt ? cand : best;
`endif
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed table-driven bench for fc_argmax plus hand-written sequences for
// staggered done, enable abort and asynchronous reset mid-scan.
module tb_fc_argmax;
  localparam int N = 10;
  localparam int W = 38;
  localparam int IW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [N*W-1:0]     score_i;
  logic [N-1:0]       done_i;
  logic [IW-1:0]      class_o;
  logic               class_valid_o;
  logic               busy_o;
`ifdef FC_ARGMAX_SCORE_EN
  logic [W-1:0]       max_score_o;
`endif

  fc_argmax #(.N_CLASS(N), .SCORE_W(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .score_i(score_i), .done_i(done_i),
    .class_o(class_o), .class_valid_o(class_valid_o),
`ifdef FC_ARGMAX_SCORE_EN
    .max_score_o(max_score_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][W-1:0] sc;
    logic [IW-1:0]       idx;
    logic [W-1:0]        mx;
  } vec_t;

  int passed = 0;
  int total  = 0;

  function automatic logic [W-1:0] s38(input longint v);
    logic [63:0] t;
    t = v;
    return t[W-1:0];
  endfunction

  function automatic logic [N-1:0][W-1:0] pk(input longint a[N]);
    logic [N-1:0][W-1:0] r;
    for (int i = 0; i < N; i++) r[i] = s38(a[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_wait(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!class_valid_o && lat < 40);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    enable = 1'b0; done_i = '0; tick();
    enable = 1'b1; score_i = v.sc; tick();
    chk({name, ".wait_busy"}, 64'(busy_o), 64'd1);
    chk({name, ".wait_valid"}, 64'(class_valid_o), 64'd0);
    done_i = '1; tick();
    chk({name, ".scan_busy"}, 64'(busy_o), 64'd1);
    scan_wait(lat);
    chk({name, ".latency"}, 64'(lat), 64'd9);
    chk({name, ".class"}, 64'(class_o), 64'(v.idx));
    chk({name, ".done_busy"}, 64'(busy_o), 64'd0);
`ifdef FC_ARGMAX_SCORE_EN
    chk({name, ".max"}, 64'(max_score_o), 64'(v.mx));
`endif
  endtask

  vec_t tv[6];

  initial begin
    int lat;
    longint p36, pmax, nmin;
    p36  = 64'sd1 <<< 36;
    pmax = (64'sd1 <<< 37) - 1;
    nmin = -(64'sd1 <<< 37);

    tv[0] = '{sc: pk('{5, -3, 100, 7, 0, 0, 0, 0, 0, -1}), idx: 4'd2, mx: s38(100)};
    tv[1] = '{sc: pk('{-50, -100, -60, nmin, -51, -70, -99, -80, -2, -55}), idx: 4'd8, mx: s38(-2)};
    tv[2] = '{sc: pk('{1, 2, 3, p36, 4, 5, p36, 6, 7, 8}), idx: 4'd3, mx: s38(p36)};
    tv[3] = '{sc: pk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 9}), idx: 4'd9, mx: s38(9)};
    tv[4] = '{sc: pk('{7, 7, 7, 7, 7, 7, 7, 7, 7, 7}), idx: 4'd0, mx: s38(7)};
    tv[5] = '{sc: pk('{-1, nmin, 3, 0, p36, pmax, -7, 1, 2, 5}), idx: 4'd5, mx: s38(pmax)};

    rst = 1'b1; enable = 1'b0; done_i = '0; score_i = '0;
    #12;
    chk("reset.class", 64'(class_o), 64'd0);
    chk("reset.valid", 64'(class_valid_o), 64'd0);
    chk("reset.busy", 64'(busy_o), 64'd0);
`ifdef FC_ARGMAX_SCORE_EN
    chk("reset.max", 64'(max_score_o), 64'd0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), tv[i]);

    // Staggered done: capture happens only on the edge that sees the last bit
    enable = 1'b0; done_i = '0; tick();
    enable = 1'b1; score_i = pk('{9, 9, 9, 9, 9, 9, 9, 9999, 9, 9}); tick();
    for (int b = 0; b < N - 1; b++) begin
      done_i[b] = 1'b1; tick();
      chk($sformatf("stag.valid%0d", b), 64'(class_valid_o), 64'd0);
      chk($sformatf("stag.busy%0d", b), 64'(busy_o), 64'd1);
    end
    score_i = pk('{1, 2, 3, 4, 1000, 5, 6, 7, 8, 9});
    done_i[N-1] = 1'b1; tick();
    score_i = pk('{1, 2, 3, 4, 1000, 5, 6, 5000, 8, 9});
    scan_wait(lat);
    chk("stag.latency", 64'(lat), 64'd9);
    chk("stag.class", 64'(class_o), 64'd4);
    done_i = '0; score_i = pk('{0, 0, 0, 0, 0, 0, 0, 0, 0, 77});
    tick(); tick(); tick();
    chk("hold.class", 64'(class_o), 64'd4);
    chk("hold.valid", 64'(class_valid_o), 64'd1);
    enable = 1'b0; tick();
    chk("drop.valid", 64'(class_valid_o), 64'd0);
    chk("drop.class_kept", 64'(class_o), 64'd4);

    // Enable dropped at scan step 4, then a full re-run
    enable = 1'b1; score_i = tv[0].sc; tick();
    done_i = '1; tick();
    for (int s = 0; s < 4; s++) tick();
    chk("abort.pre_valid", 64'(class_valid_o), 64'd0);
    enable = 1'b0; tick();
    chk("abort.valid", 64'(class_valid_o), 64'd0);
    chk("abort.busy", 64'(busy_o), 64'd0);
    chk("abort.class_kept", 64'(class_o), 64'd4);
    tick();
    chk("abort.valid2", 64'(class_valid_o), 64'd0);
    enable = 1'b1; score_i = tv[1].sc; tick();
    tick();
    scan_wait(lat);
    chk("rerun.latency", 64'(lat), 64'd9);
    chk("rerun.class", 64'(class_o), 64'd8);

    // Asynchronous reset in the middle of a scan
    enable = 1'b0; done_i = '0; tick();
    enable = 1'b1; score_i = tv[0].sc; tick();
    done_i = '1; tick();
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst.class", 64'(class_o), 64'd0);
    chk("arst.valid", 64'(class_valid_o), 64'd0);
    chk("arst.busy", 64'(busy_o), 64'd0);
`ifdef FC_ARGMAX_SCORE_EN
    chk("arst.max", 64'(max_score_o), 64'd0);
`endif
    tick();
    rst = 1'b0;
    run_vec("post_rst", tv[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Classification stage directly downstream of the fully-connected output neurons. It waits until every class neuron has raised its done flag and latches all signed class scores in one cycle. It then scans them sequentially with a signed comparator and presents the winning class index with a valid flag to the result/display logic. One scan step per cycle keeps the block to a single 38-bit comparator regardless of class count.

## Interface

Parameters:
- N_CLASS, 10, number of class neurons feeding the block (2..16)
- SCORE_W, 38, width of each signed neuron score
- IDX_W, 4, width of class index; must satisfy 2**IDX_W >= N_CLASS

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  level; same enable that drives the FC neurons; low aborts and clears
- score_i  input  N_CLASS*SCORE_W  packed signed scores, class k at bits [k*SCORE_W +: SCORE_W]
- done_i  input  N_CLASS  per-neuron done flags
- class_o  output  IDX_W  winning class index
- class_valid_o  output  1  class_o holds a result for the current enable window
- busy_o  output  1  high in CAPTURE-wait and SCAN states
- max_score_o  output  SCORE_W  signed winning score (only with FC_ARGMAX_SCORE_EN)

## Operation

- States: IDLE, WAIT, SCAN, DONE.
- IDLE: enable=1 -> WAIT.
- WAIT: busy_o=1. If all done_i bits are 1 on an edge:
  - capture all scores into the bank;
  - best <= score 0, best_idx <= 0, k <= 1;
  - go to SCAN.
  - Partial done_i keeps the block in WAIT indefinitely.
- SCAN: busy_o=1. Each cycle compare bank[k] against best as signed SCORE_W values.
  - Strictly greater replaces best and best_idx.
  - Ties keep the lower index.
  - k increments.
  - On the cycle k=N_CLASS-1: register the final result into class_o (and max_score_o), set class_valid_o=1, go to DONE.
- DONE: hold outputs. Changes in done_i and score_i are ignored because the scores are latched.
- enable=0 in any state: next edge goes to IDLE, class_valid_o <= 0, k <= 0. class_o and max_score_o keep their last value.
- enable low for one cycle and back high restarts from WAIT; scores are re-captured.
- Reset (async, any state): state=IDLE, class_o=0, class_valid_o=0, busy_o=0, max_score_o=0, bank cleared, k=0.
- Reset mid-SCAN discards the partial result.

## Timing

- Edge E0 samples all done_i=1 and captures the scores.
- Edges E1..E(N_CLASS-1) perform the compares.
- class_valid_o is high after E(N_CLASS-1): N_CLASS-1 cycles after capture (9 at default).
- busy_o is high from the edge entering WAIT through the edge entering DONE (registered, from state).
- class_valid_o falls on the first edge where enable=0.
- No combinational path from inputs to outputs.

## Configuration

- FC_ARGMAX_SCORE_EN defined:
  - max_score_o port exists;
  - it is registered together with class_o and reset to 0.
- Not defined:
  - port absent;
  - best register stays internal only.
  - Index and valid behaviour are identical either way.

## Structure

- Shared package fc_pkg holds:
  - N_CLASS, SCORE_W, IDX_W defaults;
  - typedef score_t (signed [SCORE_W-1:0]);
  - typedef class_idx_t;
  - enum fc_argmax_state_t {IDLE, WAIT, SCAN, DONE}.
- Single module. Score bank, counter and comparator are inline, and no sub-module is warranted.

## Test plan

- Scores {5,-3,100,7,0,0,0,0,0,-1}, all done together -> class_o=2, class_valid_o high exactly 9 cycles after capture edge.
- All scores negative, max -2 at index 8, others <= -50 -> class_o=8; confirms signed compare, not unsigned.
- Tie: index 3 and index 6 both 2**36 (largest score) -> class_o=3. With FC_ARGMAX_SCORE_EN, max_score_o=2**36.
- done_i raised one bit per cycle over 10 cycles -> stays WAIT until the last bit; capture uses values present on that edge. Scores changed after capture do not affect the result.
- enable dropped at SCAN step 4 -> IDLE next edge, class_valid_o stays 0. Re-enable with all done -> full 9-cycle scan, correct index.
- rst pulsed asynchronously mid-SCAN -> all outputs 0 immediately; after release with enable=1 and all done -> normal result.
